hilo_unit: RTL

//  HI/LO side of the ALU mul/div interface: takes ALU we_hi/we_lo/hi_out/lo_out in EX and carries them through
//  EX/MEM and MEM/WB slots. Commits them to the architectural HI/LO registers at WB.

---
 rtl/hilo_pkg.sv | 36 +++
 rtl/hilo_slot.sv | 24 ++
 rtl/hilo_unit.sv | 97 +++++++++
 3 files changed

// File: rtl/hilo_pkg.sv
// Shared types and constants for the HI/LO writeback unit.
// Bypass build is selected with the HILO_BYPASS_EN macro (see hilo_unit).
package hilo_pkg;

  // Register data width and the write/reset polarities used across the core
  localparam int unsigned REG_DATA_WIDTH = 32;
  localparam logic        WRITE_ENABLE   = 1'b1;
  localparam logic        RST_ENABLE     = 1'b1;
  localparam logic [REG_DATA_WIDTH-1:0] ZERO_WORD = '0;

  // One in-flight HI/LO write; HI and LO enables are independent
  typedef struct packed {
    logic                      we_hi;
    logic                      we_lo;
    logic [REG_DATA_WIDTH-1:0] hi;
    logic [REG_DATA_WIDTH-1:0] lo;
  } slot_t;

  localparam slot_t SLOT_BUBBLE = '0;

  // Youngest-write-wins selection for one half
  function automatic logic [REG_DATA_WIDTH-1:0] hilo_pick(
    input logic                      m_we,
    input logic [REG_DATA_WIDTH-1:0] m_d,
    input logic                      w_we,
    input logic [REG_DATA_WIDTH-1:0] w_d,
    input logic [REG_DATA_WIDTH-1:0] arch
  );
    logic [REG_DATA_WIDTH-1:0] r;
    r = arch;
    if (w_we == WRITE_ENABLE) r = w_d;
    if (m_we == WRITE_ENABLE) r = m_d;
    return r;
  endfunction

endpackage

// File: rtl/hilo_slot.sv
// One HI/LO pipeline slot with hold and bubble-insert controls.
module hilo_slot
  import hilo_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  hold,
  input  logic  bubble,
  input  slot_t d,
  output slot_t q
);

  // Reset wins, then bubble (even while held), then hold, else load
  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      q <= SLOT_BUBBLE;
    end else if (bubble) begin
      q <= SLOT_BUBBLE;
    end else if (!hold) begin
      q <= d;
    end
  end

endmodule

// File: rtl/hilo_unit.sv
// HI/LO side of the mul/div interface: EX -> M -> W slots, commit at WB,
// and HI/LO read values returned to the ALU.
// Macro HILO_BYPASS_EN: defined -> forward from M/W, hazard_stall tied 0;
// undefined -> read architectural HI/LO and request stalls on pending writes.
// DW must equal hilo_pkg::REG_DATA_WIDTH.
module hilo_unit
  import hilo_pkg::*;
#(
  parameter int unsigned DW = REG_DATA_WIDTH
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          stall,
  input  logic          flush,
  input  logic          ex_we_hi,
  input  logic          ex_we_lo,
  input  logic [DW-1:0] ex_hi,
  input  logic [DW-1:0] ex_lo,
  input  logic          ex_rd_hi,
  input  logic          ex_rd_lo,
  output logic [DW-1:0] hi_in,
  output logic [DW-1:0] lo_in,
  output logic          hazard_stall,
  output logic [DW-1:0] hi_q,
  output logic [DW-1:0] lo_q
);

  slot_t ex_slot;
  slot_t m_slot;
  slot_t w_slot;

  // Pack the EX-stage ALU outputs into a slot payload
  always_comb begin
    ex_slot       = SLOT_BUBBLE;
    ex_slot.we_hi = ex_we_hi;
    ex_slot.we_lo = ex_we_lo;
    ex_slot.hi    = REG_DATA_WIDTH'(ex_hi);
    ex_slot.lo    = REG_DATA_WIDTH'(ex_lo);
  end

  // EX/MEM slot: flush turns it into a bubble regardless of stall
  hilo_slot u_m (
    .clk    (clk),
    .rst    (rst),
    .hold   (stall),
    .bubble (flush),
    .d      (ex_slot),
    .q      (m_slot)
  );

  // MEM/WB slot: never flushed, only held
  hilo_slot u_w (
    .clk    (clk),
    .rst    (rst),
    .hold   (stall),
    .bubble (1'b0),
    .d      (m_slot),
    .q      (w_slot)
  );

  // Architectural commit from the W slot, per half
  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      hi_q <= DW'(ZERO_WORD);
      lo_q <= DW'(ZERO_WORD);
    end else if (!stall) begin
      if (w_slot.we_hi == WRITE_ENABLE) hi_q <= DW'(w_slot.hi);
      if (w_slot.we_lo == WRITE_ENABLE) lo_q <= DW'(w_slot.lo);
    end
  end

`ifdef HILO_BYPASS_EN
  // Read-port inputs only matter when stalls are generated instead of forwarding
  logic unused_rd;
  assign unused_rd = ex_rd_hi ^ ex_rd_lo;

  // Forward the youngest in-flight write, else the architectural value
  always_comb begin
    hi_in        = hi_q;
    lo_in        = lo_q;
    hazard_stall = 1'b0;
    hi_in = DW'(hilo_pick(m_slot.we_hi, m_slot.hi, w_slot.we_hi, w_slot.hi,
                          REG_DATA_WIDTH'(hi_q)));
    lo_in = DW'(hilo_pick(m_slot.we_lo, m_slot.lo, w_slot.we_lo, w_slot.lo,
                          REG_DATA_WIDTH'(lo_q)));
  end
`else
  // No forwarding: read committed state and stall readers behind pending writes
  always_comb begin
    hi_in        = hi_q;
    lo_in        = lo_q;
    hazard_stall = (ex_rd_hi & (m_slot.we_hi | w_slot.we_hi)) |
                   (ex_rd_lo & (m_slot.we_lo | w_slot.we_lo));
  end
`endif

endmodule
